ex_muldiv: RTL

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/ex_muldiv_div_iter.sv | 53 +++++
 rtl/ex_muldiv.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit:
// funct3 op codes, FSM state encoding and iteration count.
package muldiv_pkg;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  localparam int unsigned ITER_CNT = 32;

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Radix-2 restoring divider datapath on unsigned magnitudes.
// quo_o/rem_o expose this cycle's step result for final sign fix-up.
module div_iter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] dvd_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] quo_o,
  output logic [W-1:0] rem_o
);

  logic [W-1:0] q_q, q_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] d_q, d_d;
  logic [W:0]   r_sh;
  logic [W:0]   diff;

  always_comb begin
    r_sh  = {r_q, q_q[W-1]};
    diff  = r_sh - {1'b0, d_q};
    // Top bit of diff is the borrow: restore when set.
    quo_o = {q_q[W-2:0], ~diff[W]};
    rem_o = diff[W] ? r_sh[W-1:0] : diff[W-1:0];
    q_d   = q_q;
    r_d   = r_q;
    d_d   = d_q;
    if (load_i) begin
      q_d = dvd_i;
      r_d = '0;
      d_d = dvs_i;
    end else if (step_i) begin
      q_d = quo_o;
      r_d = rem_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
      r_q <= '0;
      d_q <= '0;
    end else begin
      q_q <= q_d;
      r_q <= r_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage RV32M multiply/divide unit with stall handshake.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module ex_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  E_Flush,
  input  logic                  E_MulDivValid,
  input  logic [2:0]            E_Funct3,
  input  logic [DATA_WIDTH-1:0] E_SrcA,
  input  logic [DATA_WIDTH-1:0] E_SrcB,
  output logic                  E_MulDivBusy,
  output logic                  E_MulDivDone,
  output logic [DATA_WIDTH-1:0] E_MulDivResult
);

  import muldiv_pkg::*;

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(ITER_CNT);
  localparam logic [CW-1:0] LAST = CW'(ITER_CNT - 1);
  localparam logic [W-1:0]  ONES = '1;
  localparam logic [W-1:0]  SMIN = {1'b1, {(W-1){1'b0}}};

  state_e         state_q, state_d;
  funct3_e        op_q, op_d, op_i;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic           aneg_q, aneg_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [W-1:0]   res_q, res_d;

  logic           start, is_div, div_go;
  logic           a_sgn, b_sgn, a_neg, b_neg;
  logic           dz, ovf;
  logic [W-1:0]   a_mag, b_mag, imm_res;
  logic [W-1:0]   quo_nx, rem_nx, qv, rv;
  logic [2*W-1:0] acc_sum;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] prod_fast;
`endif

  function automatic logic [W-1:0] mul_pick(
    input funct3_e        op,
    input logic           neg,
    input logic [2*W-1:0] p
  );
    logic [2*W-1:0] ps;
    ps = neg ? -p : p;
    return (op == F3_MUL) ? ps[W-1:0] : ps[2*W-1:W];
  endfunction

  // Sign handling: work on magnitudes, fix signs at the end.
  always_comb begin
    op_i    = funct3_e'(E_Funct3);
    is_div  = E_Funct3[2];
    a_sgn   = is_div ? ~E_Funct3[0] : (E_Funct3 != 3'd3);
    b_sgn   = is_div ? ~E_Funct3[0] : ~E_Funct3[1];
    a_neg   = a_sgn & E_SrcA[W-1];
    b_neg   = b_sgn & E_SrcB[W-1];
    a_mag   = a_neg ? -E_SrcA : E_SrcA;
    b_mag   = b_neg ? -E_SrcB : E_SrcB;
    dz      = is_div & (E_SrcB == '0);
    ovf     = is_div & ~E_Funct3[0] &
              (E_SrcA == SMIN) & (E_SrcB == ONES);
    imm_res = E_Funct3[1] ? (dz ? E_SrcA : '0)
                          : (dz ? ONES : SMIN);
  end

  assign start  = (state_q == S_IDLE) & E_MulDivValid &
                  ~E_Flush & ~rst;
  assign div_go = start & is_div & ~dz & ~ovf;

  assign E_MulDivBusy   = start | (state_q == S_MUL) |
                          (state_q == S_DIV);
  assign E_MulDivDone   = (state_q == S_DONE) & ~E_Flush;
  assign E_MulDivResult = res_q;

  div_iter #(.W(W)) u_div (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (div_go),
    .step_i (state_q == S_DIV),
    .dvd_i  (a_mag),
    .dvs_i  (b_mag),
    .quo_o  (quo_nx),
    .rem_o  (rem_nx)
  );

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign qv      = neg_q ? -quo_nx : quo_nx;
  assign rv      = aneg_q ? -rem_nx : rem_nx;
`ifdef MULDIV_FAST_MUL_EN
  assign prod_fast = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    aneg_d   = aneg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    res_d    = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op_i;
          neg_d  = a_neg ^ b_neg;
          aneg_d = a_neg;
          cnt_d  = '0;
          if (dz | ovf) begin
            res_d   = imm_res;
            state_d = S_DONE;
          end else if (is_div) begin
            state_d = S_DIV;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            res_d   = mul_pick(op_i, a_neg ^ b_neg, prod_fast);
            state_d = S_DONE;
`else
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, a_mag};
            mplier_d = b_mag;
            state_d  = S_MUL;
`endif
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          res_d   = mul_pick(op_q, neg_q, acc_sum);
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          res_d   = op_q[1] ? rv : qv;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase
    // A flushed op never completes and never touches the result.
    if (E_Flush) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= F3_MUL;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      aneg_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      aneg_q   <= aneg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      res_q    <= res_d;
    end
  end

endmodule
